// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of CHANNELS registered-flag FIFOs into one valid/ready stream.
// Each grant takes up to BURST words. Each pop is followed by a settle cycle while the source flags catch up.
module fifo_drain_arbiter #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int BURST    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [CHANNELS-1:0]           src_nempty,
  input  logic [CHANNELS*WIDTH-1:0]     src_data,
  output logic [CHANNELS-1:0]           src_pop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_chan,
  output logic                          out_first,
  output logic                          busy
);
  localparam int CW = $clog2(CHANNELS);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, POP, SETTLE, CONT} state_t;

  state_t                             state, state_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0]     data_arr;
  logic [CW-1:0]                      last_grant, scan_g, sel;
  logic [BW-1:0]                      beats;
  logic                               scan_hit, slot_free, burst_done;
  logic                               cap_idle, cap_cont, capture;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign data_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Scan starts one past the previous grant; CW-bit addition wraps for power-of-two CHANNELS.
  always_comb begin
    scan_hit = 1'b0;
    scan_g   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!scan_hit && src_nempty[last_grant + CW'(i)]) begin
        scan_hit = 1'b1;
        scan_g   = last_grant + CW'(i);
      end
    end
  end

  assign slot_free  = !out_valid || out_ready;
  assign burst_done = (beats == BW'(BURST)) || !src_nempty[last_grant];
  assign cap_idle   = (state == IDLE) && enable && scan_hit && slot_free;
  assign cap_cont   = (state == CONT) && !burst_done && slot_free;
  assign capture    = cap_idle || cap_cont;
  assign sel        = cap_idle ? scan_g : last_grant;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_idle) state_nxt = POP;
      POP:     state_nxt = SETTLE;
      SETTLE:  state_nxt = CONT;
      CONT:    if (burst_done) state_nxt = IDLE;
               else if (slot_free) state_nxt = POP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_pop    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      out_first  <= 1'b0;
      beats      <= '0;
      last_grant <= CW'(CHANNELS - 1);
    end else begin
      src_pop <= '0;
      if (capture) begin
        src_pop[sel] <= 1'b1;
        out_valid    <= 1'b1;
        out_data     <= data_arr[sel];
        out_chan     <= sel;
        out_first    <= cap_idle;
        beats        <= cap_idle ? BW'(1) : beats + BW'(1);
        if (cap_idle) last_grant <= scan_g;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
